// File: rtl/shifter_pkg.sv
// Shared op codes, FSM state encoding and op decode helper for the iterative shifter.
package shifter_pkg;

    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_ROTR = 6'b000110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Unsupported codes run as a zero-length shift.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves i_value by i_k (0..STEP) positions per the op code.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    parameter int unsigned KW    = 6
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [KW-1:0]    i_k,
    input  logic [5:0]       i_op,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned KS = $clog2(STEP) + 1;

    logic [WIDTH-1:0] w_lvl [KS+1];
    logic             w_unused_k;

    // Only the low KS bits of k can be set because k never exceeds STEP.
    assign w_unused_k = ^i_k;
    assign w_lvl[0]   = i_value;

    // Level i conditionally shifts by 2**i.
    for (genvar i = 0; i < KS; i++) begin : g_lvl
        localparam int unsigned SH = 1 << i;
        logic [WIDTH-1:0] w_sh;

        always_comb begin
            w_sh = w_lvl[i];
            case (i_op)
                OP_SLL:  w_sh = w_lvl[i] << SH;
                OP_SRL:  w_sh = w_lvl[i] >> SH;
                OP_SRA:  w_sh = ({WIDTH{i_sign}} << (WIDTH - SH)) | (w_lvl[i] >> SH);
                OP_ROTR: w_sh = (w_lvl[i] >> SH) | (w_lvl[i] << (WIDTH - SH));
                default: w_sh = w_lvl[i];
            endcase
        end

        assign w_lvl[i+1] = i_k[i] ? w_sh : w_lvl[i];
    end

    assign o_result = w_lvl[KS];

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit shifting at most STEP positions per clock,
// with a start/busy/done handshake and a result register held between ops.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned KW  = SHW + 1;

    state_t           r_state;
    logic [SHW-1:0]   r_rem;
    logic [WIDTH-1:0] r_val;
    logic [5:0]       r_op;
    logic             r_sign;
    logic             r_busy;
    logic             r_done;

    logic [SHW-1:0]   w_amt;
    logic [KW-1:0]    w_rem_ext;
    logic [KW-1:0]    w_k;
    logic [SHW-1:0]   w_rem_next;
    logic [WIDTH-1:0] w_step;
    logic             w_unused_b;

    assign w_amt      = op_supported(Signal) ? dataB[SHW-1:0] : '0;
    assign w_unused_b = ^dataB[WIDTH-1:SHW];

    // Step size is min(rem, STEP); compared one bit wider since STEP may equal WIDTH.
    assign w_rem_ext  = {1'b0, r_rem};
    assign w_k        = (w_rem_ext > KW'(STEP)) ? KW'(STEP) : w_rem_ext;
    assign w_rem_next = SHW'(w_rem_ext - w_k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_shift_step (
        .i_value  (r_val),
        .i_k      (w_k),
        .i_op     (r_op),
        .i_sign   (r_sign),
        .o_result (w_step)
    );

    // Control FSM; DONE accepts a new start exactly like IDLE for back-to-back ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_val   <= '0;
            r_op    <= OP_SLL;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_val  <= dataA;
                        r_op   <= Signal;
                        r_sign <= dataA[WIDTH-1];
                        r_rem  <= w_amt;
                        if (w_amt != '0) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_val <= w_step;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_val;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_iterative_shifter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEP  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;

    int checks   = 0;
    int failures = 0;

    iterative_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic supported(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b000010 || op == 6'b000011 || op == 6'b000110;
    endfunction

    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned amt;
        amt = b % 32;
        case (op)
            6'b000000: return a << amt;
            6'b000010: return a >> amt;
            6'b000011: return 32'($signed(a) >>> amt);
            6'b000110: return (a >> amt) | (a << (32 - amt));
            default:   return a;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op, input logic [31:0] b);
        int unsigned amt;
        amt = supported(op) ? (b % 32) : 0;
        return 1 + int'((amt + STEP - 1) / STEP);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge where done is seen.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int edges;
        int lat;
        lat    = latency(op, b);
        Signal = op;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
        Signal = 6'($urandom);
        edges  = 1;
        check({tag, ".busy"}, 32'(busy), 32'(lat > 1));
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".lat"}, 32'(edges), 32'(lat));
        check({tag, ".data"}, dataOut, model(op, a, b));
    endtask

    initial begin
        int pulses;
        int first_edge;
        int second_edge;
        logic [31:0] first_data;
        logic [5:0] op;
        logic [31:0] a;
        logic [31:0] b;

        reset  = 1'b1;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.data", dataOut, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("srl31", 6'b000010, 32'h8000_0000, 32'd31);
        check("srl31.val", dataOut, 32'h0000_0001);
        // done is a single-cycle pulse and dataOut holds while idle
        @(posedge clk); #1;
        check("srl31.pulse", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle.hold", dataOut, 32'h0000_0001);

        run_op("sra5", 6'b000011, 32'hF000_0000, 32'd5);
        check("sra5.val", dataOut, 32'hFF80_0000);
        run_op("srl5", 6'b000010, 32'hF000_0000, 32'd5);
        check("srl5.val", dataOut, 32'h0780_0000);
        run_op("rotr1", 6'b000110, 32'h0000_0001, 32'd1);
        check("rotr1.val", dataOut, 32'h8000_0000);
        run_op("sll0", 6'b000000, 32'h0000_0001, 32'd0);
        run_op("bad", 6'b111111, 32'h1234_ABCD, 32'd7);
        check("bad.val", dataOut, 32'h1234_ABCD);
        run_op("amt_mask", 6'b000011, 32'hF000_0000, 32'h0000_0105);
        check("amt_mask.val", dataOut, 32'hFF80_0000);
        run_op("sll_step", 6'b000000, 32'h0000_FFFF, 32'd16);
        run_op("rotr31", 6'b000110, 32'h0000_0003, 32'd31);

        // start held high through busy with the operands changing
        @(posedge clk); #1;
        Signal = 6'b000010;
        dataA  = 32'h8000_0000;
        dataB  = 32'd8;
        start  = 1'b1;
        pulses = 0;
        first_edge = 0;
        second_edge = 0;
        first_data = '0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                Signal = 6'b000000;
                dataA  = 32'h0000_FFFF;
                dataB  = 32'd4;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_edge = e;
                    first_data = dataOut;
                end else if (pulses == 2) begin
                    second_edge = e;
                    start = 1'b0;
                end
            end
        end
        check("hold.pulses", 32'(pulses), 32'd2);
        check("hold.first_edge", 32'(first_edge), 32'd3);
        check("hold.first_data", first_data, 32'h0080_0000);
        check("hold.second_edge", 32'(second_edge), 32'd5);
        check("hold.second_data", dataOut, 32'h000F_FFF0);

        // asynchronous reset in the middle of a long shift
        Signal = 6'b000010;
        dataA  = 32'hDEAD_BEEF;
        dataB  = 32'd20;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort.busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.data", dataOut, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort.no_done", 32'(pulses), 32'd0);

        // randomized ops, sometimes back to back through DONE, sometimes with idle gaps
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 6'b000000;
                1: op = 6'b000010;
                2: op = 6'b000011;
                3: op = 6'b000110;
                default: op = 6'($urandom);
            endcase
            a = $urandom;
            b = $urandom;
            run_op($sformatf("rand%0d", n), op, a, b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
